// File: rtl/ft601_bus_ctrl.sv
// FT601 245-synchronous FIFO bus controller: time-shares the 32-bit tristate
// bus between the host-to-device read stream and the device-to-host write stream.
module ft601_bus_ctrl #(
   parameter int MaxBurst   = 64,
   parameter int TurnCycles = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        usb_rxf_ni,
   input  logic        usb_txe_ni,
   input  logic [31:0] usb_data_i,
   output logic [31:0] usb_data_o,
   output logic        usb_data_oe,
   output logic [3:0]  usb_be_o,
   output logic        usb_be_oe,
   output logic        usb_rd_no,
   output logic        usb_wr_no,
   output logic        usb_oe_no,
   output logic        rx_valid_o,
   output logic [31:0] rx_data_o,
   input  logic        rx_afull_i,
   input  logic        tx_valid_i,
   input  logic [31:0] tx_data_i,
   input  logic [3:0]  tx_be_i,
   output logic        tx_ready_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {IDLE, RD_OE, RD, RD_END, WR, TURN} state_t;

   localparam logic [7:0] BurstMax  = 8'(MaxBurst);
   localparam logic [7:0] BurstLast = 8'(MaxBurst - 1);
   localparam logic [1:0] TurnLast  = 2'(TurnCycles - 1);

   state_t     state;
   logic [7:0] burst_cnt;
   logic [1:0] turn_cnt;
   logic       last_wr;
   logic       wr_pend;

   logic rd_elig, wr_elig, rd_cap, rd_exit;
   logic wr_accept, wr_hit, wr_exit, wr_load;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // The burst limit in WR first blocks new loads, then leaves once the
   // holding register has drained, so a loaded word is never abandoned.
   always_comb begin
      rd_elig    = !usb_rxf_ni && !rx_afull_i;
      wr_elig    = tx_valid_i && !usb_txe_ni;
      rd_cap     = (state == RD) && !usb_rd_no && !usb_rxf_ni;
      rd_exit    = usb_rxf_ni || rx_afull_i ||
                   (rd_cap && wr_elig && (burst_cnt >= BurstLast));
      wr_accept  = (state == WR) && wr_pend && !usb_txe_ni;
      wr_hit     = (burst_cnt >= BurstMax) && rd_elig;
      wr_exit    = (state == WR) && !wr_pend && (wr_hit || !tx_valid_i || usb_txe_ni);
      tx_ready_o = !rst_i && (state == WR) && !wr_exit && !wr_hit &&
                   (!wr_pend || !usb_txe_ni);
      wr_load    = tx_ready_o && tx_valid_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         burst_cnt   <= 8'd0;
         turn_cnt    <= 2'd0;
         last_wr     <= 1'b1;
         wr_pend     <= 1'b0;
         usb_data_o  <= 32'd0;
         usb_data_oe <= 1'b0;
         usb_be_o    <= 4'd0;
         usb_be_oe   <= 1'b0;
         usb_rd_no   <= 1'b1;
         usb_wr_no   <= 1'b1;
         usb_oe_no   <= 1'b1;
         rx_valid_o  <= 1'b0;
         rx_data_o   <= 32'd0;
         busy_o      <= 1'b0;
      end else begin
         // rx push stage: one word per strobed edge, presented one cycle later
         rx_valid_o <= 1'b0;
         if (rd_cap) begin
            rx_valid_o <= 1'b1;
            rx_data_o  <= usb_data_i;
         end

         unique case (state)
            IDLE: begin
               if (rd_elig && (!wr_elig || last_wr)) begin
                  state     <= RD_OE;
                  usb_oe_no <= 1'b0;
                  last_wr   <= 1'b0;
                  burst_cnt <= 8'd0;
                  busy_o    <= 1'b1;
               end else if (wr_elig) begin
                  state       <= WR;
                  usb_data_oe <= 1'b1;
                  usb_be_oe   <= 1'b1;
                  last_wr     <= 1'b1;
                  burst_cnt   <= 8'd0;
                  busy_o      <= 1'b1;
               end
            end
            RD_OE: begin
               state     <= RD;
               usb_rd_no <= 1'b0;
            end
            RD: begin
               if (rd_cap) burst_cnt <= sat_inc(burst_cnt);
               if (rd_exit) begin
                  state     <= RD_END;
                  usb_rd_no <= 1'b1;
               end
            end
            RD_END: begin
               state     <= TURN;
               usb_oe_no <= 1'b1;
               turn_cnt  <= 2'd0;
            end
            WR: begin
               if (wr_load) begin
                  wr_pend    <= 1'b1;
                  usb_wr_no  <= 1'b0;
                  usb_data_o <= tx_data_i;
                  usb_be_o   <= tx_be_i;
                  burst_cnt  <= sat_inc(burst_cnt);
               end else if (wr_accept) begin
                  wr_pend   <= 1'b0;
                  usb_wr_no <= 1'b1;
               end
               if (wr_exit) begin
                  state    <= TURN;
                  turn_cnt <= 2'd0;
               end
            end
            TURN: begin
               // after a write the bus is released one edge after the last strobe
               if (usb_data_oe) begin
                  usb_data_oe <= 1'b0;
                  usb_be_oe   <= 1'b0;
               end else if (turn_cnt == TurnLast) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  turn_cnt <= turn_cnt + 2'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ft601_bus_ctrl.md
Name: ft601_bus_ctrl

Overview:
- Sequences the FT601 245-synchronous-FIFO bus on the USB clock.
- Arbitrates the single shared 32-bit tristate bus between the host-to-device read stream (RX) and the device-to-host write stream (TX).
- Drives the split data_o/data_oe/be_o/be_oe pad signals that the core's IOBUF split exposes.
- Guarantees bus turnaround gaps, and bounds each burst so neither direction starves the other.

Parameters:
- MaxBurst, 64: maximum words per burst when the opposite direction is eligible (range 1..255).
- TurnCycles, 1: idle cycles with data_oe=0 and all strobes high between direction changes (range 1..3).

Ports:
- clk_i  in  1  FT601 clock (usb_clk).
- rst_i  in  1  synchronous reset, active-high.
- usb_rxf_ni  in  1  low = FT601 has RX data.
- usb_txe_ni  in  1  low = FT601 has TX space.
- usb_data_i  in  32  bus read value.
- usb_data_o  out  32  bus drive value.
- usb_data_oe  out  1  data drive enable.
- usb_be_o  out  4  byte enables for writes.
- usb_be_oe  out  1  be drive enable.
- usb_rd_no  out  1  read strobe, active-low.
- usb_wr_no  out  1  write strobe, active-low.
- usb_oe_no  out  1  FT601 output enable, active-low.
- rx_valid_o  out  1  one received word, push-only (no backpressure).
- rx_data_o  out  32  received word.
- rx_afull_i  in  1  downstream has room for 2 or fewer words; stop reading.
- tx_valid_i  in  1  TX word offered.
- tx_data_i  in  32  TX word.
- tx_be_i  in  4  TX byte enables.
- tx_ready_o  out  1  TX word accepted on this edge when tx_valid_i=1.
- busy_o  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Registered outputs: all usb_* outputs and rx_* outputs come from flops. tx_ready_o is combinational from state and flops plus usb_txe_ni.
- Reset values: rd_no=1, wr_no=1, oe_no=1, data_oe=0, be_oe=0, data_o=0, be_o=0, rx_valid_o=0, rx_data_o=0, busy_o=0, tx_ready_o=0, last_dir=WR (so the first tie goes to RD).
- Reset mid-burst: the next edge forces the reset values; any pending TX word and any in-flight RX word are discarded.
- Eligibility: rd_elig = !usb_rxf_ni & !rx_afull_i; wr_elig = tx_valid_i & !usb_txe_ni.
- IDLE:
  - Only rd_elig: go to RD_OE. Only wr_elig: go to WR.
  - Both: serve the direction opposite last_dir.
  - On entry to a burst: clear burst_cnt, set last_dir.
- RD_OE: oe_no=0, data_oe=0; 1 cycle, then RD.
- RD:
  - oe_no=0, rd_no=0.
  - Each edge where rd_no=0 and usb_rxf_ni=0: capture usb_data_i; next cycle rx_valid_o=1 with that data (latency 1); burst_cnt++.
  - Exit to RD_END when any of: usb_rxf_ni=1; rx_afull_i=1; burst_cnt==MaxBurst-1 with a capture and wr_elig.
- RD_END: rd_no=1 on entry, oe_no=1 one cycle later.
  - A word captured on the rd_no-deassert edge is still pushed; downstream absorbs at most 2 words after rx_afull_i.
  - Then go to TURN.
- WR:
  - Holding register wr_pend/data/be. data_oe=be_oe=1 for the whole state. usb_wr_no = !wr_pend.
  - Pending word accepted on an edge where wr_pend=1 and usb_txe_ni=0; otherwise held and re-presented unchanged.
  - tx_ready_o = (state==WR) & !exit & (!wr_pend | !usb_txe_ni).
  - On a tx handshake: load the register next cycle and burst_cnt++.
  - exit when any of: burst_cnt==MaxBurst with rd_elig; tx_valid_i=0 with no pending word; usb_txe_ni=1 with no pending word.
  - On exit: wr_no=1; data_oe=be_oe=0 on the following edge; go to TURN.
- Pending-word rule: a pending word is never dropped except by reset. If txe_ni stays high, the block waits in WR indefinitely.
- TURN: all strobes high, data_oe=0 for TurnCycles cycles, then IDLE.
- Bus-contention invariant: data_oe=1 and oe_no=0 are never asserted in the same cycle.
- burst_cnt: 8-bit counter, saturates and never wraps.

Test Plan:
- Read-only: rxf_ni low for 10 words (0x100..0x109), tx_valid_i=0 -> oe_no falls 1 cycle before rd_no; 10 rx_valid_o pulses with data 0x100..0x109 in order, each 1 cycle after capture; busy_o returns to 0.
- Write with stall: 5 TX words, txe_ni high for 3 cycles mid-burst -> wr_no stays low, the held word is re-presented unchanged, exactly 5 words accepted, no duplicates, be_o matches tx_be_i.
- Contention: rxf_ni and tx_valid_i both permanently active, MaxBurst=4 -> alternating bursts of 4 reads then 4 writes; at least TurnCycles cycles with all strobes high between bursts; data_oe and !oe_no never overlap.
- Backpressure: assert rx_afull_i mid read burst -> rd_no high within 1 cycle; at most 2 further rx_valid_o pulses.
- Reset mid-write: assert rst_i with wr_pend=1 -> next edge wr_no=1, data_oe=0, busy_o=0; after release, the first tie goes to RD.
